fpga_cfg_loader: RTL and testbench

//  Drives the serial CRAM configuration chain that runs through the fpgacell array.
//  - Write side: takes bitstream words over a valid/ready handshake and serialises them LSB-first onto the chain input.
//  - Read side: captures the bits shifted out of the chain end, packs them into words and returns them as a readback stream.
//  - Holds the fabric logic enable low while configuration is in progress.

---
 rtl/fpga_cfg_loader.sv | 163 ++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_cfg_loader.sv
// Serial CRAM configuration loader: serialises bitstream words onto the chain head
// and packs the bits leaving the chain tail into readback words.
module fpga_cfg_loader #(
    parameter int WORD_W     = 32,
    parameter int CHAIN_BITS = 1024,
    parameter int CNT_W      = $clog2(CHAIN_BITS + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    input  logic              rb_ready,
    output logic              cfg_en,
    output logic              cfg_sdo,
    input  logic              cfg_sdi,
    output logic              le_en_gate,
    output logic              busy,
    output logic              done
);

    localparam int NB_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, RBOUT, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [NB_W-1:0]     nbits_q, nbits_d;
    logic [NB_W-1:0]     sh_cnt_q, sh_cnt_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [WORD_W-1:0]   rb_sr_q, rb_sr_d;
    logic [WORD_W-1:0]   rb_data_q, rb_data_d;
    logic                cfg_en_q, cfg_en_d;
    logic                cfg_sdo_q, cfg_sdo_d;
    logic                word_ready_q, word_ready_d;
    logic                rb_valid_q, rb_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                le_en_gate_q, le_en_gate_d;
    int                  remain;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        nbits_d      = nbits_q;
        sh_cnt_d     = sh_cnt_q;
        data_d       = data_q;
        rb_sr_d      = rb_sr_q;
        rb_data_d    = rb_data_q;
        cfg_en_d     = cfg_en_q;
        cfg_sdo_d    = cfg_sdo_q;
        word_ready_d = word_ready_q;
        rb_valid_d   = rb_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        le_en_gate_d = le_en_gate_q;
        remain       = CHAIN_BITS - int'(bit_cnt_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    bit_cnt_d    = '0;
                    busy_d       = 1'b1;
                    le_en_gate_d = 1'b0;
                    word_ready_d = 1'b1;
                end
            end
            LOAD: begin
                // A short final word only shifts the bits still missing from the chain.
                if (word_valid && word_ready_q) begin
                    data_d       = word_data;
                    nbits_d      = NB_W'((remain < WORD_W) ? remain : WORD_W);
                    sh_cnt_d     = '0;
                    rb_sr_d      = '0;
                    word_ready_d = 1'b0;
                    cfg_en_d     = 1'b1;
                    cfg_sdo_d    = word_data[0];
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                data_d    = data_q >> 1;
                cfg_sdo_d = data_q[1];
                rb_sr_d   = rb_sr_q | (WORD_W'(cfg_sdi) << sh_cnt_q);
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                sh_cnt_d  = sh_cnt_q + NB_W'(1);
                if (sh_cnt_q == nbits_q - NB_W'(1)) begin
                    cfg_en_d   = 1'b0;
                    cfg_sdo_d  = 1'b0;
                    rb_valid_d = 1'b1;
                    rb_data_d  = rb_sr_d;
                    state_d    = RBOUT;
                end
            end
            RBOUT: begin
                if (rb_ready) begin
                    rb_valid_d = 1'b0;
                    if (bit_cnt_q == CNT_W'(CHAIN_BITS)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = LOAD;
                        word_ready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                busy_d       = 1'b0;
                le_en_gate_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            nbits_q      <= '0;
            sh_cnt_q     <= '0;
            data_q       <= '0;
            rb_sr_q      <= '0;
            rb_data_q    <= '0;
            cfg_en_q     <= 1'b0;
            cfg_sdo_q    <= 1'b0;
            word_ready_q <= 1'b0;
            rb_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            le_en_gate_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            nbits_q      <= nbits_d;
            sh_cnt_q     <= sh_cnt_d;
            data_q       <= data_d;
            rb_sr_q      <= rb_sr_d;
            rb_data_q    <= rb_data_d;
            cfg_en_q     <= cfg_en_d;
            cfg_sdo_q    <= cfg_sdo_d;
            word_ready_q <= word_ready_d;
            rb_valid_q   <= rb_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            le_en_gate_q <= le_en_gate_d;
        end
    end

    assign word_ready = word_ready_q;
    assign rb_valid   = rb_valid_q;
    assign rb_data    = rb_data_q;
    assign cfg_en     = cfg_en_q;
    assign cfg_sdo    = cfg_sdo_q;
    assign le_en_gate = le_en_gate_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader on a 40-bit chain: a stream-level model predicts the
// shifted bits, readback words and handshake timing; directed loads pin the model.
module tb_fpga_cfg_loader;

    logic        clk;
    logic        nrst;
    logic        start;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        rb_valid;
    logic [31:0] rb_data;
    logic        rb_ready;
    logic        cfg_en;
    logic        cfg_sdo;
    logic        cfg_sdi;
    logic        le_en_gate;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    fpga_cfg_loader #(.WORD_W(32), .CHAIN_BITS(40)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .rb_valid   (rb_valid),
        .rb_data    (rb_data),
        .rb_ready   (rb_ready),
        .cfg_en     (cfg_en),
        .cfg_sdo    (cfg_sdo),
        .cfg_sdi    (cfg_sdi),
        .le_en_gate (le_en_gate),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The CRAM chain: head takes cfg_sdo, index 39 is the tail feeding cfg_sdi.
    logic [39:0] chain = 40'h5A_C3F0_1E96;
    always @(posedge clk) if (cfg_en) chain <= {chain[38:0], cfg_sdo};
    assign cfg_sdi = chain[39];

    // Stream model: img[i] is the i-th bit that entered the chain during the last full load.
    logic [39:0] img, new_img;
    bit          img_valid, rb_chk, rst_prev;
    bit          busy_exp, wr_exp, rbv_exp, done_exp;
    int          sh_left, acc, cur_run, done_cnt;
    bit          sdo_q[$];
    logic [31:0] rb_exp[$];
    int          runs[$];
    bit          sdo_log[$];
    logic [31:0] rb_log[$];
    bit          hold_prev;
    logic [31:0] rb_prev;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          o_wr, o_rbv, o_done, o_busy;
        int          o_sh, nb;
        logic [31:0] w;
        for (int i = 0; i < 40; i++) img[i] = chain[39 - i];
        img_valid = 1'b1;
        rst_prev  = 1'b1;
        hold_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                checkOutput("rst_cfg_en", cfg_en, 0);
                checkOutput("rst_cfg_sdo", cfg_sdo, 0);
                checkOutput("rst_word_ready", word_ready, 0);
                checkOutput("rst_rb_valid", rb_valid, 0);
                checkOutput("rst_rb_data", rb_data, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_done", done, 0);
                checkOutput("rst_le_en_gate", le_en_gate, 1);
            end else begin
                checkOutput("busy", busy, busy_exp);
                checkOutput("le_en_gate", le_en_gate, !busy_exp);
                checkOutput("done", done, done_exp);
                checkOutput("cfg_en", cfg_en, sh_left > 0);
                checkOutput("word_ready", word_ready, wr_exp);
                checkOutput("rb_valid", rb_valid, rbv_exp);
                if (sh_left > 0) begin
                    if (sdo_q.size() == 0) timeoutFail("cfg_sdo_underflow");
                    else checkOutput("cfg_sdo", cfg_sdo, sdo_q.pop_front());
                end
                if (hold_prev && rbv_exp) checkOutput("rb_hold", rb_data, rb_prev);
                if (rbv_exp && rb_ready) begin
                    if (rb_exp.size() == 0) timeoutFail("rb_underflow");
                    else begin
                        w = rb_exp.pop_front();
                        if (rb_chk) checkOutput("rb_data", rb_data, w);
                    end
                end
            end

            if (cfg_en) begin
                cur_run++;
                sdo_log.push_back(cfg_sdo);
            end else if (cur_run > 0) begin
                runs.push_back(cur_run);
                cur_run = 0;
            end
            if (done) done_cnt++;
            if (rb_valid && rb_ready) rb_log.push_back(rb_data);
            hold_prev = rb_valid && !rb_ready;
            rb_prev   = rb_data;

            o_wr = wr_exp; o_rbv = rbv_exp; o_done = done_exp; o_busy = busy_exp; o_sh = sh_left;
            if (!nrst) begin
                if (busy_exp) img_valid = 1'b0;
                busy_exp = 0; wr_exp = 0; rbv_exp = 0; done_exp = 0; sh_left = 0;
                sdo_q.delete();
                rb_exp.delete();
                rst_prev = 1'b1;
            end else begin
                rst_prev = 1'b0;
                done_exp = 1'b0;
                if (o_done) busy_exp = 1'b0;
                if (o_sh > 0) begin
                    sh_left = o_sh - 1;
                    if (sh_left == 0) rbv_exp = 1'b1;
                end
                if (o_wr && word_valid) begin
                    nb = (40 - acc < 32) ? 40 - acc : 32;
                    for (int i = 0; i < nb; i++) begin
                        sdo_q.push_back(word_data[i]);
                        new_img[acc + i] = word_data[i];
                    end
                    acc     = acc + nb;
                    sh_left = nb;
                    wr_exp  = 1'b0;
                    if (acc == 40) begin
                        img       = new_img;
                        img_valid = 1'b1;
                    end
                end
                if (o_rbv && rb_ready) begin
                    rbv_exp = 1'b0;
                    if (acc == 40) done_exp = 1'b1;
                    else wr_exp = 1'b1;
                end
                if (start && !o_busy) begin
                    busy_exp = 1'b1;
                    wr_exp   = 1'b1;
                    acc      = 0;
                    new_img  = '0;
                    rb_chk   = img_valid;
                    rb_exp.delete();
                    rb_exp.push_back(img[31:0]);
                    rb_exp.push_back({24'h0, img[39:32]});
                end
            end
        end
    end

    task automatic clearLogs();
        runs.delete();
        sdo_log.delete();
        rb_log.delete();
        done_cnt = 0;
    endtask

    // One full two-word load with optional word gaps, readback stall and a stray start pulse.
    task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1,
                                 input int gap, input int stall, input bit poke);
        logic [31:0] w[2];
        bit ok, preloaded;
        w[0] = w0;
        w[1] = w1;
        preloaded = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!preloaded) begin
                word_valid = 1'b0;
                repeat (gap) step();
                word_valid = 1'b1;
                word_data  = w[k];
            end
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (word_ready) begin ok = 1'b1; break; end
            end
            @(posedge clk);
            #1;
            word_valid = 1'b0;
            word_data  = $urandom;
            preloaded  = 1'b0;
            if (!ok) timeoutFail("word_handshake");
            if (poke && k == 0) begin
                repeat (3) step();
                start = 1'b1;
                step();
                start = 1'b0;
            end
            rb_ready = (stall == 0);
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (rb_valid) begin ok = 1'b1; break; end
            end
            if (!ok) timeoutFail("rb_valid_wait");
            if (stall > 0) begin
                if (k == 0 && gap == 0) begin
                    word_valid = 1'b1;
                    word_data  = w[1];
                    preloaded  = 1'b1;
                end
                repeat (stall) step();
                rb_ready = 1'b1;
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            rb_ready = 1'b0;
        end
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        if (!ok) timeoutFail("done_wait");
        step();
    endtask

    task automatic resetMidLoad();
        bit ok;
        start = 1'b1;
        step();
        start = 1'b0;
        word_valid = 1'b1;
        word_data  = 32'hCAFE_F00D;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (word_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        if (!ok) timeoutFail("reset_word_handshake");
        repeat (9) step();
        nrst = 1'b0;
        step();
        @(negedge clk);
        checkOutput("t6_cfg_en", cfg_en, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_le_en_gate", le_en_gate, 1);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] f0, f1, r1;
        logic [39:0] s, exp_chain;
        nrst = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0; rb_ready = 1'b0;
        repeat (3) step();
        nrst = 1'b1;
        clearLogs();
        repeat (20) step();
        checkOutput("t1_idle_no_shift", runs.size() + cur_run, 0);

        clearLogs();
        applyStimulus(32'hDEADBEEF, 32'h000000A5, 0, 0, 0);
        checkOutput("t2_run0", (runs.size() > 0) ? runs[0] : -1, 32);
        checkOutput("t2_run1", (runs.size() > 1) ? runs[1] : -1, 8);
        s = '0;
        for (int i = 0; i < 8 && i < sdo_log.size(); i++) s[i] = sdo_log[i];
        checkOutput("t2_sdo_first8", s[7:0], 8'hEF);
        checkOutput("t2_done_cnt", done_cnt, 1);
        r1 = (rb_log.size() > 1) ? rb_log[1] : 32'hFFFF_FFFF;
        checkOutput("t2_rb1_upper", r1[31:8], 24'h0);

        clearLogs();
        applyStimulus(32'h12345678, 32'h0000003C, 0, 0, 0);
        checkOutput("t3_rb0", (rb_log.size() > 0) ? rb_log[0] : 32'hX, 32'hDEADBEEF);
        checkOutput("t3_rb1", (rb_log.size() > 1) ? rb_log[1] : 32'hX, 32'h000000A5);

        clearLogs();
        applyStimulus(32'hA1B2C3D4, 32'h0000005E, 0, 10, 0);
        checkOutput("t4_rb0", (rb_log.size() > 0) ? rb_log[0] : 32'hX, 32'h12345678);
        checkOutput("t4_rb1", (rb_log.size() > 1) ? rb_log[1] : 32'hX, 32'h0000003C);
        checkOutput("t4_done_cnt", done_cnt, 1);
        s = {8'h5E, 32'hA1B2C3D4};
        for (int i = 0; i < 40; i++) exp_chain[39 - i] = s[i];
        checkOutput("t4_chain", chain, exp_chain);

        clearLogs();
        applyStimulus($urandom, $urandom, 5, 0, 1);
        checkOutput("t5_rb0", (rb_log.size() > 0) ? rb_log[0] : 32'hX, 32'hA1B2C3D4);
        checkOutput("t5_rb1", (rb_log.size() > 1) ? rb_log[1] : 32'hX, 32'h0000005E);
        checkOutput("t5_done_cnt", done_cnt, 1);

        resetMidLoad();
        f0 = $urandom;
        f1 = $urandom;
        applyStimulus(f0, f1, 0, 0, 0);
        clearLogs();
        applyStimulus($urandom, $urandom, 1, 2, 0);
        checkOutput("t6_rb0", (rb_log.size() > 0) ? rb_log[0] : 32'hX, f0);
        checkOutput("t6_rb1", (rb_log.size() > 1) ? rb_log[1] : 32'hX, {24'h0, f1[7:0]});

        for (int n = 0; n < 6; n++) begin
            applyStimulus($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom % 2));
        end
        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
